// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte sources with round-robin arbitration.
// Define SCHED_FIXED_PRIO_EN to use fixed priority instead (lowest index wins).
module uart_tx_scheduler #(
   parameter int WIDTH     = 8,
   parameter int N_REQ     = 4,
   parameter int ACCEPT_TO = 15
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   input  logic [N_REQ-1:0]         req_par_en,
   input  logic [N_REQ-1:0]         req_par_type,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         nack,
   output logic [WIDTH-1:0]         tx_data,
   output logic                     tx_data_valid,
   output logic                     tx_par_en,
   output logic                     tx_par_type,
   input  logic                     tx_busy,
   input  logic                     tx_can_send,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     sched_busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(ACCEPT_TO + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACC, WAIT_FREE} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_data_q, tx_data_d;
   logic             tx_par_en_q, tx_par_en_d;
   logic             tx_par_type_q, tx_par_type_d;
   logic             tx_data_valid_q, tx_data_valid_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [N_REQ-1:0] nack_q, nack_d;
   logic             sched_busy_q, sched_busy_d;

   logic [WIDTH-1:0] req_data_arr [N_REQ];
   logic             sel_valid;
   logic [ID_W-1:0]  sel_id;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

`ifdef SCHED_FIXED_PRIO_EN
   // Descending scan so the lowest set index is the last (winning) assignment.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel_valid = 1'b1;
            sel_id    = ID_W'(i);
         end
      end
   end
`else
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [ID_W:0]      sel_sum;

   // Rotate requests so bit 0 is the source just after the last grant.
   always_comb begin
      req_dbl   = {req, req};
      req_rot   = req_dbl[({1'b0, rr_ptr_q} + (ID_W+1)'(1)) +: N_REQ];
      sel_valid = 1'b0;
      sel_sum   = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            sel_valid = 1'b1;
            sel_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(1) + (ID_W+1)'(j);
         end
      end
      if (sel_sum >= (ID_W+1)'(N_REQ)) begin
         sel_sum = sel_sum - (ID_W+1)'(N_REQ);
      end
      sel_id = sel_sum[ID_W-1:0];
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == ISSUE && tx_can_send) begin
         rr_ptr_d = grant_id_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         rr_ptr_q <= ID_W'(N_REQ - 1);
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_comb begin
      state_d         = state_q;
      grant_id_d      = grant_id_q;
      cnt_d           = cnt_q;
      tx_data_d       = tx_data_q;
      tx_par_en_d     = tx_par_en_q;
      tx_par_type_d   = tx_par_type_q;
      tx_data_valid_d = 1'b0;
      ack_d           = '0;
      nack_d          = '0;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d       = ISSUE;
               grant_id_d    = sel_id;
               tx_data_d     = req_data_arr[sel_id];
               tx_par_en_d   = req_par_en[sel_id];
               tx_par_type_d = req_par_type[sel_id];
            end
         end
         ISSUE: begin
            if (tx_can_send) begin
               tx_data_valid_d = 1'b1;
               ack_d           = N_REQ'(1) << grant_id_q;
               cnt_d           = '0;
               state_d         = WAIT_ACC;
            end
         end
         WAIT_ACC: begin
            // The earlier ack stands; nack only flags that the frame never started.
            if (tx_busy) begin
               state_d = WAIT_FREE;
            end else if (cnt_q == CNT_W'(ACCEPT_TO - 1)) begin
               nack_d  = N_REQ'(1) << grant_id_q;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_FREE: begin
            if (tx_can_send) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      sched_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q         <= IDLE;
         grant_id_q      <= '0;
         cnt_q           <= '0;
         tx_data_q       <= '0;
         tx_par_en_q     <= 1'b0;
         tx_par_type_q   <= 1'b0;
         tx_data_valid_q <= 1'b0;
         ack_q           <= '0;
         nack_q          <= '0;
         sched_busy_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         grant_id_q      <= grant_id_d;
         cnt_q           <= cnt_d;
         tx_data_q       <= tx_data_d;
         tx_par_en_q     <= tx_par_en_d;
         tx_par_type_q   <= tx_par_type_d;
         tx_data_valid_q <= tx_data_valid_d;
         ack_q           <= ack_d;
         nack_q          <= nack_d;
         sched_busy_q    <= sched_busy_d;
      end
   end

   assign ack           = ack_q;
   assign nack          = nack_q;
   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_data_valid_q;
   assign tx_par_en     = tx_par_en_q;
   assign tx_par_type   = tx_par_type_q;
   assign grant_id      = grant_id_q;
   assign sched_busy    = sched_busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a scoreboard of expected frames and a
// simple transmitter model; honours SCHED_FIXED_PRIO_EN for the grant order.
module tb_uart_tx_scheduler;

   localparam int WIDTH     = 8;
   localparam int N_REQ     = 4;
   localparam int ACCEPT_TO = 15;
   localparam int FRAME_LEN = 10;

   logic                   CLK = 1'b0;
   logic                   Reset = 1'b1;
   logic [N_REQ-1:0]       req = '0;
   logic [N_REQ*WIDTH-1:0] req_data = '0;
   logic [N_REQ-1:0]       req_par_en = '0;
   logic [N_REQ-1:0]       req_par_type = '0;
   logic [N_REQ-1:0]       ack;
   logic [N_REQ-1:0]       nack;
   logic [WIDTH-1:0]       tx_data;
   logic                   tx_data_valid;
   logic                   tx_par_en;
   logic                   tx_par_type;
   logic                   tx_busy;
   logic                   tx_can_send;
   logic [1:0]             grant_id;
   logic                   sched_busy;

   uart_tx_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ACCEPT_TO(ACCEPT_TO)) dut (
      .CLK(CLK), .Reset(Reset), .req(req), .req_data(req_data),
      .req_par_en(req_par_en), .req_par_type(req_par_type),
      .ack(ack), .nack(nack), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
      .tx_par_en(tx_par_en), .tx_par_type(tx_par_type), .tx_busy(tx_busy),
      .tx_can_send(tx_can_send), .grant_id(grant_id), .sched_busy(sched_busy)
   );

   always #5 CLK = ~CLK;

   // Transmitter model: a Data_valid pulse starts a frame of FRAME_LEN+1 busy cycles.
   logic model_busy   = 1'b0;
   int   frame_cnt    = 0;
   logic model_ignore = 1'b0;
   logic block_send   = 1'b0;

   always @(posedge CLK) begin
      if (model_busy) begin
         if (frame_cnt == 0) model_busy <= 1'b0;
         else                frame_cnt  <= frame_cnt - 1;
      end else if (tx_data_valid && !model_ignore) begin
         model_busy <= 1'b1;
         frame_cnt  <= FRAME_LEN;
      end
   end

   assign tx_busy     = model_busy;
   assign tx_can_send = !model_busy && !block_send;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       pen;
      logic       ptype;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] src_data  [N_REQ];
   logic       src_pen   [N_REQ];
   logic       src_ptype [N_REQ];
   int         n_pass = 0;
   int         n_fail = 0;
   int         n_total = 0;
   int         order [5];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int i, input logic [7:0] d, input logic pe, input logic pt);
      src_data[i]  = d;
      src_pen[i]   = pe;
      src_ptype[i] = pt;
      req_data[i*WIDTH +: WIDTH] = d;
      req_par_en[i]   = pe;
      req_par_type[i] = pt;
   endtask

   task automatic push_exp(input int i);
      exp_t e;
      e.id    = 2'(i);
      e.data  = src_data[i];
      e.pen   = src_pen[i];
      e.ptype = src_ptype[i];
      sb.push_back(e);
   endtask

   // Steps at least one cycle, then up to budget more, waiting for the Data_valid pulse.
   task automatic expect_frame(input string tag, input int budget);
      exp_t       e;
      int         n;
      logic [3:0] a_exp;
      n = 0;
      @(negedge CLK);
      while (tx_data_valid !== 1'b1 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk({tag, "_valid"}, 32'(tx_data_valid), 1);
      chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e     = sb.pop_front();
         a_exp = 4'(1) << e.id;
         $display("frame %s: grant=%0d data=%02h pen=%0d ptype=%0d ack=%b", tag, grant_id,
                  tx_data, tx_par_en, tx_par_type, ack);
         chk({tag, "_grant"}, 32'(grant_id), 32'(e.id));
         chk({tag, "_data"},  32'(tx_data),  32'(e.data));
         chk({tag, "_pen"},   32'(tx_par_en),   32'(e.pen));
         chk({tag, "_ptype"}, 32'(tx_par_type), 32'(e.ptype));
         chk({tag, "_ack"},   32'(ack),  32'(a_exp));
         chk({tag, "_nack"},  32'(nack), 0);
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (sched_busy !== 1'b0 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      chk(tag, 32'(sched_busy), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ack"},   32'(ack), 0);
      chk({tag, "_nack"},  32'(nack), 0);
      chk({tag, "_data"},  32'(tx_data), 0);
      chk({tag, "_valid"}, 32'(tx_data_valid), 0);
      chk({tag, "_pen"},   32'(tx_par_en), 0);
      chk({tag, "_ptype"}, 32'(tx_par_type), 0);
      chk({tag, "_grant"}, 32'(grant_id), 0);
      chk({tag, "_busy"},  32'(sched_busy), 0);
   endtask

   initial begin
      int k;
      int n;
`ifdef SCHED_FIXED_PRIO_EN
      order = '{0, 0, 0, 0, 0};
`else
      order = '{0, 1, 2, 3, 0};
`endif
      set_src(0, 8'hA5, 1'b1, 1'b1);
      set_src(1, 8'h3C, 1'b0, 1'b0);
      set_src(2, 8'h5A, 1'b1, 1'b0);
      set_src(3, 8'hC3, 1'b0, 1'b1);

      Reset = 1'b1;
      repeat (3) @(negedge CLK);
      check_reset_outputs("rst");
      Reset = 1'b0;

      // Single request: latched at the first edge, pulse after the second.
      req = 4'b0001;
      push_exp(0);
      @(negedge CLK);
      chk("t1_lat_valid", 32'(tx_data_valid), 0);
      chk("t1_lat_busy", 32'(sched_busy), 1);
      chk("t1_lat_data", 32'(tx_data), 32'h A5);
      expect_frame("t1", 0);
      req = 4'b0000;
      @(negedge CLK);
      chk("t1_ack_once", 32'(ack), 0);
      wait_idle("t1_idle", 40);

      // All sources requesting continuously.
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         push_exp(order[f]);
         expect_frame("t2", 40);
      end
      req = 4'b0000;
      wait_idle("t2_idle", 40);

      // Transmitter refuses for 20 cycles after the grant.
      block_send = 1'b1;
      req = 4'b0100;
      push_exp(2);
      @(negedge CLK);
      chk("t3_grant", 32'(grant_id), 2);
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         chk("t3_hold_valid", 32'(tx_data_valid), 0);
         chk("t3_hold_data", 32'(tx_data), 32'h5A);
      end
      block_send = 1'b0;
      expect_frame("t3", 0);
      req = 4'b0000;
      wait_idle("t3_idle", 40);

      // Transmitter never goes busy: accept timeout, then the next request is served.
      model_ignore = 1'b1;
      req = 4'b1000;
      push_exp(3);
      expect_frame("t4", 4);
      req = 4'b0010;
      k = 0;
      while (nack === 4'b0000 && k < 30) begin
         @(negedge CLK);
         k++;
      end
      $display("timeout: nack=%b after %0d cycles", nack, k);
      chk("t4_nack_delay", 32'(k), ACCEPT_TO);
      chk("t4_nack_val", 32'(nack), 32'h8);
      chk("t4_nack_no_ack", 32'(ack), 0);
      chk("t4_nack_idle", 32'(sched_busy), 0);
      model_ignore = 1'b0;
      push_exp(1);
      expect_frame("t4_next", 6);
      chk("t4_nack_once", 32'(nack), 0);

      // Source data changes while the frame is on the wire.
      req = 4'b0000;
      repeat (3) @(negedge CLK);
      chk("t5_in_free", 32'(sched_busy), 1);
      set_src(1, 8'hEE, 1'b1, 1'b1);
      n = 0;
      while (sched_busy === 1'b1 && n < 40) begin
         chk("t5_hold", 32'(tx_data), 32'h3C);
         @(negedge CLK);
         n++;
      end
      chk("t5_idle", 32'(sched_busy), 0);
      repeat (2) @(negedge CLK);
      chk("t5_hold_idle", 32'(tx_data), 32'h3C);
      chk("t5_hold_pen", 32'(tx_par_en), 0);
      req = 4'b0010;
      push_exp(1);
      expect_frame("t5_new", 4);
      req = 4'b0000;
      wait_idle("t5_new_idle", 40);

      // Reset in the middle of a transmitted frame.
      req = 4'b0100;
      push_exp(2);
      expect_frame("t6_pre", 4);
      req = 4'b0000;
      repeat (4) @(negedge CLK);
      chk("t6_pre_busy", 32'(sched_busy), 1);
      Reset = 1'b1;
      req = 4'b1111;
      @(negedge CLK);
      check_reset_outputs("t6_rst");
      Reset = 1'b0;
      push_exp(0);
      expect_frame("t6_first", 30);
      req = 4'b0000;
      wait_idle("t6_idle", 40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
